gshare_predictor: RTL and testbench

//  Parametrised direction predictor for the fetch stage: table of N-bit saturating counters,

---
 rtl/branch_pkg.sv | 31 +++
 rtl/sat_counter_table.sv | 45 ++++
 rtl/gshare_predictor.sv | 109 ++++++++++
 tb/tb_gshare_predictor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared predictor constants and saturating counter step helper.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Widest counter the helper supports; narrower counters are zero-extended.
    localparam int CTR_MAX_W    = 4;

    function automatic logic [CTR_MAX_W-1:0] ctr_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          ctr_w
    );
        logic [CTR_MAX_W-1:0] w_top;
        w_top = CTR_MAX_W'((32'd1 << ctr_w) - 32'd1);
        if (taken) begin
            return (ctr == w_top) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter_table.sv
// ============================================================================
// Module      : sat_counter_table
// Description : Array of saturating counters, async reset, 1 read / 1 update port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter_table
    import branch_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [CTR_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic             wr_taken
);

    localparam int c_depth = 2 ** IDX_W;

    logic [CTR_W-1:0] r_mem [c_depth];
    logic [CTR_W-1:0] w_next_ctr;

    // Combinational read sees the stored value, so a colliding update lands next cycle.
    assign rd_data    = r_mem[rd_addr];
    assign w_next_ctr = CTR_W'(ctr_next(CTR_MAX_W'(r_mem[wr_addr]), wr_taken, CTR_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= CTR_W'(INIT_CTR);
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= w_next_ctr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gshare_predictor.sv
// ============================================================================
// Module      : gshare_predictor
// Description : Bimodal/gshare direction predictor with history and mispredict count.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gshare_predictor
    import branch_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int HIST_LEN = 8,
    parameter int MODE     = 1,
    parameter int INIT_CTR = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pred_pc,
    output logic                pred_taken,
    output logic [IDX_W-1:0]    pred_idx,
    input  logic                upd_valid,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken,
    input  logic                upd_pred,
    output logic [HIST_LEN-1:0] ghr,
    output logic [CNT_W-1:0]    mispredict_cnt
);

    if (HIST_LEN > IDX_W || HIST_LEN < 1) begin : g_bad_hist
        $error("gshare_predictor: HIST_LEN must be in 1..IDX_W");
    end
    if (CTR_W < 2 || CTR_W > CTR_MAX_W) begin : g_bad_ctr
        $error("gshare_predictor: CTR_W must be in 2..4");
    end
    if (INIT_CTR < 0 || INIT_CTR >= (1 << CTR_W)) begin : g_bad_init
        $error("gshare_predictor: INIT_CTR out of counter range");
    end
    if (MODE != MODE_BIMODAL && MODE != MODE_GSHARE) begin : g_bad_mode
        $error("gshare_predictor: MODE must be 0 or 1");
    end
    if (PC_WIDTH < IDX_W + 2) begin : g_bad_pc
        $error("gshare_predictor: PC_WIDTH too narrow for IDX_W");
    end

    logic [IDX_W-1:0]    w_pc_idx;
    logic [IDX_W-1:0]    w_idx;
    logic [CTR_W-1:0]    w_rd_ctr;
    logic [HIST_LEN-1:0] r_ghr;
    logic [HIST_LEN-1:0] w_ghr_next;
    logic [CNT_W-1:0]    r_mispredict_cnt;
    logic                w_mispredict;
    logic                w_unused_pc_bits;

    // Instructions are word aligned; only the index field of the PC feeds the hash.
    assign w_pc_idx         = pred_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^pred_pc;

    if (MODE == MODE_GSHARE) begin : g_gshare
        assign w_idx = w_pc_idx ^ IDX_W'(r_ghr);
    end else begin : g_bimodal
        assign w_idx = w_pc_idx;
    end

    if (HIST_LEN == 1) begin : g_hist_one
        assign w_ghr_next = upd_taken;
    end else begin : g_hist_shift
        assign w_ghr_next = {r_ghr[HIST_LEN-2:0], upd_taken};
    end

    assign pred_idx       = w_idx;
    assign pred_taken     = w_rd_ctr[CTR_W-1];
    assign ghr            = r_ghr;
    assign mispredict_cnt = r_mispredict_cnt;
    assign w_mispredict   = upd_valid && (upd_taken != upd_pred);

    sat_counter_table #(
        .IDX_W    (IDX_W),
        .CTR_W    (CTR_W),
        .INIT_CTR (INIT_CTR)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (w_idx),
        .rd_data  (w_rd_ctr),
        .wr_en    (upd_valid),
        .wr_addr  (upd_idx),
        .wr_taken (upd_taken)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr            <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (upd_valid) begin
                r_ghr <= w_ghr_next;
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_predictor.sv
// ============================================================================
// Module      : tb_gshare_predictor
// Description : Directed checks of bimodal, gshare and narrow-counter predictors.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gshare_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [7:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;

    logic        bi_taken, gs_taken, sa_taken;
    logic [7:0]  bi_idx, gs_idx, sa_idx;
    logic [7:0]  bi_ghr, gs_ghr, sa_ghr;
    logic [15:0] bi_cnt, gs_cnt;
    logic [3:0]  sa_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    gshare_predictor #(.MODE(0)) dut_bi (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(bi_taken), .pred_idx(bi_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(bi_ghr), .mispredict_cnt(bi_cnt)
    );

    gshare_predictor #(.MODE(1)) dut_gs (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(gs_taken), .pred_idx(gs_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(gs_ghr), .mispredict_cnt(gs_cnt)
    );

    gshare_predictor #(.MODE(0), .CNT_W(4)) dut_sa (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(sa_taken), .pred_idx(sa_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .ghr(sa_ghr), .mispredict_cnt(sa_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [7:0] idx, input logic taken, input logic pred);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        upd_pred  = pred;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        pred_pc   = 32'h0000_1234;
        upd_valid = 1'b0;
        upd_idx   = '0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;

        // Reset state
        #2;
        check("rst_bi_taken", bi_taken, 0);
        check("rst_gs_taken", gs_taken, 0);
        check("rst_gs_ghr",   gs_ghr,   0);
        check("rst_gs_cnt",   gs_cnt,   0);
        rst = 1'b1;
        #1;

        // Bimodal training on index 5
        pred_pc = 32'h14;
        #1;
        check("bi_idx5",      bi_idx,   8'h05);
        check("bi_init",      bi_taken, 0);
        upd(8'h05, 1'b1, 1'b0);
        check("bi_after1",    bi_taken, 0);
        upd(8'h05, 1'b1, 1'b0);
        check("bi_after2",    bi_taken, 1);
        for (int i = 0; i < 3; i++) upd(8'h05, 1'b1, 1'b1);
        upd(8'h05, 1'b0, 1'b1);
        check("bi_3to2",      bi_taken, 1);
        check("bi_ghr_kept",  bi_ghr,   8'h3E);
        check("bi_mis3",      bi_cnt,   3);
        upd(8'h05, 1'b0, 1'b0);
        check("bi_2to1",      bi_taken, 0);
        check("bi_idle_ghr",  bi_ghr,   8'h7C);
        tick();
        check("bi_hold_ghr",  bi_ghr,   8'h7C);

        // gshare hashing
        pulse_reset();
        upd(8'h00, 1'b1, 1'b1);
        upd(8'h00, 1'b1, 1'b1);
        upd(8'h00, 1'b0, 1'b0);
        check("gs_ghr_ttn",   gs_ghr,   8'h06);
        pred_pc = 32'h40;
        #1;
        check("gs_idx",       gs_idx,   8'h16);
        check("bi_idx_nohash", bi_idx,  8'h10);
        check("gs_cnt_zero",  gs_cnt,   0);

        // Same-cycle collision, no bypass
        pred_pc = 32'h58;
        upd(8'h16, 1'b1, 1'b1);
        check("col_ctr1",     bi_taken, 0);
        upd_valid = 1'b1;
        upd_idx   = 8'h16;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        #1;
        check("col_idx",      bi_idx,   8'h16);
        check("col_same",     bi_taken, 0);
        tick();
        upd_valid = 1'b0;
        check("col_next",     bi_taken, 1);

        // Mispredict counter saturation
        pulse_reset();
        for (int i = 0; i < 14; i++) upd(8'h01, i[0], ~i[0]);
        check("sat_14",       sa_cnt,   14);
        for (int i = 0; i < 6; i++) upd(8'h01, i[0], ~i[0]);
        for (int i = 0; i < 5; i++) upd(8'h01, 1'b1, 1'b1);
        check("sat_15",       sa_cnt,   15);
        check("wide_20",      bi_cnt,   20);

        // Asynchronous reset between edges drops the pending update
        pulse_reset();
        pred_pc = 32'h0C;
        for (int i = 0; i < 3; i++) upd(8'h03, 1'b1, 1'b1);
        check("rm_trained",   bi_taken, 1);
        check("rm_ghr7",      bi_ghr,   8'h07);
        upd_valid = 1'b1;
        upd_idx   = 8'h03;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rm_async_taken", bi_taken, 0);
        check("rm_async_ghr",   bi_ghr,   0);
        tick();
        upd_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rm_drop_ghr",    bi_ghr,   0);
        check("rm_drop_cnt",    bi_cnt,   0);
        check("rm_drop_taken",  bi_taken, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
